io_uart_tx: RTL and testbench
=============================

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, gives the clock cycles per serial bit (10 MHz / 115200 baud); legal range 2..4095.
REQ-002 Parameter FIFO_DEPTH, default 4, gives the TX FIFO entries; power of two, 2..16.
REQ-003 CLK  in  1  system clock; all state updates on rising edge; the block has one clock.
REQ-004 RESET  in  1  reset, synchronous, active-low (0 = reset on the next rising CLK edge).
REQ-005 IOWriteData  in  32  processor store data; only [7:0] is used for TXDATA and [1:0] for CTRL.
REQ-006 IOAddr  in  4  I/O byte address within the processor I/O window.
REQ-007 IOWriteEn  in  1  1 = valid store to IOAddr this cycle.
REQ-008 IOReadData  out  32  register read data; combinational from IOAddr and current state, so a load completes in the same cycle.
REQ-009 TxD  out  1  serial line, 8N1, idle high.

Function
REQ-010 Register map: 0x0 TXDATA (write-only, reads 0), 0x4 STATUS, 0x8 CTRL; all other addresses read 0x00000000 and ignore writes.
REQ-011 STATUS fields: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky), [8:4] FIFO count; all other bits read 0.
REQ-012 A write to STATUS with any data clears overflow on that edge.
REQ-013 CTRL fields: [0] enable (read/write); [1] flush (write-1 pulse, reads 0).
REQ-014 A write to TXDATA with full=0 pushes IOWriteData[7:0]; count increments on that edge.
REQ-015 A write to TXDATA with full=1 and no pop on the same edge discards the data and sets overflow.
REQ-016 A write to TXDATA with full=1 on the same edge as a pop is accepted; count is unchanged; overflow is not set.
REQ-017 Flush empties the FIFO (count=0) on that edge and does not abort the frame in progress. Flush wins over a pop on the same edge. A simultaneous TXDATA write is discarded without setting overflow.
REQ-018 FIFO read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-019 FSM states are IDLE, START, DATA, STOP.
REQ-020 IDLE -> START when enable=1 and empty=0. The head byte is popped into the shift register on that edge.
REQ-021 START lasts CLKS_PER_BIT cycles with TxD=0, then moves to DATA.
REQ-022 DATA lasts 8×CLKS_PER_BIT cycles and sends the shift register LSB first, one bit per CLKS_PER_BIT cycles, then moves to STOP.
REQ-023 STOP lasts CLKS_PER_BIT cycles with TxD=1, then returns to IDLE.
REQ-024 A frame is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames insert exactly one IDLE cycle between the STOP bit and the next START bit.
REQ-025 Clearing enable mid-frame completes the current frame; no new frame starts while enable=0.
REQ-026 Latency: a TXDATA write at edge N, with the block idle, enabled and the FIFO empty, gives TxD=0 after edge N+1.
REQ-027 TxD is driven from a register (glitch-free); it is 1 in IDLE and STOP.
REQ-028 The bit-period counter and the bit index are internal registers sized for CLKS_PER_BIT-1 and 7 respectively; they reset to 0 at each bit and state boundary.

Reset
REQ-029 With RESET=0 at a rising edge, the following take effect on that edge: FSM=IDLE, FIFO empty (pointers and count 0), enable=0, overflow=0, counters 0, TxD=1.
REQ-030 After reset, STATUS reads 0x00000002 and CTRL reads 0x00000000.
REQ-031 Reset mid-frame aborts the frame: TxD=1 after that edge and queued bytes are lost.
REQ-032 Writes presented while RESET=0 are ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Reset: hold RESET=0 for 2 edges -> TxD=1; STATUS=0x00000002; CTRL=0x00000000.
REQ-034 Single frame: write CTRL=0x1, then TXDATA=0xA5 -> from edge N+1, TxD = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy=1 for 40 cycles; then STATUS=0x00000002.
REQ-035 Overflow: with enable=0, write TXDATA 5 times (0x11..0x15) -> STATUS=0x00000049. Then write STATUS -> STATUS=0x00000041. Then enable -> bytes 0x11..0x14 are sent in order and 0x15 never appears.
REQ-036 Push on full with pop: fill 4 bytes with enable=0, then write CTRL=0x1 and a 5th TXDATA on the edge the FSM leaves IDLE -> count stays 4, overflow=0, five frames are sent.
REQ-037 Flush mid-frame: enable, queue 3 bytes, flush during the DATA bits of frame 1 -> frame 1 completes intact; no further frames; STATUS=0x00000002 after STOP.
REQ-038 Reset mid-frame: assert RESET=0 during the DATA state -> TxD=1 after that edge; STATUS=0x00000002; no further TxD transitions with enable=0.

Source files
------------

// File: rtl/io_uart_tx_if.sv
// Processor I/O store/load port for the UART transmitter.
// Master is the CPU side, slave is the peripheral.
interface io_uart_tx_if;
    logic [31:0] IOWriteData;
    logic [3:0]  IOAddr;
    logic        IOWriteEn;
    logic [31:0] IOReadData;

    modport master (
        output IOWriteData,
        output IOAddr,
        output IOWriteEn,
        input  IOReadData
    );

    modport slave (
        input  IOWriteData,
        input  IOAddr,
        input  IOWriteEn,
        output IOReadData
    );
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: TXDATA 0x0, STATUS 0x4, CTRL 0x8.
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    io_uart_tx_if.slave  bus,
    output logic         TxD
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          enable;
    logic          overflow;

    logic sel_tx, sel_st, sel_ct;
    logic wr_tx, wr_st, wr_ct;
    logic full, empty, busy;
    logic flush, pop, push;
    logic [4:0]  cnt5;
    logic [31:0] rdata;
    logic        unused_wdata;

    assign sel_tx = (bus.IOAddr == 4'h0);
    assign sel_st = (bus.IOAddr == 4'h4);
    assign sel_ct = (bus.IOAddr == 4'h8);

    assign wr_tx = bus.IOWriteEn & sel_tx;
    assign wr_st = bus.IOWriteEn & sel_st;
    assign wr_ct = bus.IOWriteEn & sel_ct;

    assign full  = (count == CFULL);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // Flush beats both the FSM pop and a same-edge push.
    assign flush = wr_ct & bus.IOWriteData[1];
    assign pop   = (state == IDLE) & enable & ~empty & ~flush;
    assign push  = wr_tx & ~flush & (~full | pop);

    assign cnt5 = 5'(count);
    assign unused_wdata = ^bus.IOWriteData[31:8];

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_st:  rdata = {23'd0, cnt5, overflow,
                              busy, empty, full};
            sel_ct:  rdata = {31'd0, enable};
            default: rdata = '0;
        endcase
    end

    assign bus.IOReadData = rdata;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ct)
                enable <= bus.IOWriteData[0];
            if (wr_st)
                overflow <= 1'b0;
            else if (wr_tx & full & ~pop & ~flush)
                overflow <= 1'b1;
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop)
                    rptr <= rptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && push)
            mem[wptr] <= bus.IOWriteData[7:0];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            bcnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
            TxD   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state <= START;
                        shreg <= mem[rptr];
                        TxD   <= 1'b0;
                        bcnt  <= '0;
                        bidx  <= '0;
                    end
                end
                START: begin
                    if (bcnt == BLAST) begin
                        bcnt  <= '0;
                        state <= DATA;
                        TxD   <= shreg[0];
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bcnt == BLAST) begin
                        bcnt <= '0;
                        if (bidx == 3'd7) begin
                            bidx  <= '0;
                            state <= STOP;
                            TxD   <= 1'b1;
                        end else begin
                            bidx  <= bidx + 1'b1;
                            shreg <= {1'b0, shreg[7:1]};
                            TxD   <= shreg[1];
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bcnt == BLAST) begin
                        bcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Scoreboard bench for io_uart_tx: a line receiver decodes TxD
// and checks each frame against the queue of bytes expected.
module tb_io_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RESET;
    logic TxD;
    int   cyc = 0;

    io_uart_tx_if bus ();

    io_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave),
        .TxD  (TxD)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h",
                     nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input logic [3:0] a,
                      input logic [31:0] d);
        bus.IOAddr      = a;
        bus.IOWriteData = d;
        bus.IOWriteEn   = 1'b1;
        @(negedge CLK);
        bus.IOWriteEn   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a,
                      output logic [31:0] d);
        bus.IOAddr = a;
        #1;
        d = bus.IOReadData;
    endtask

    task automatic chk_reg(input string nm,
                           input logic [3:0] a,
                           input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        n_cmp++;
        if (t >= 3000) begin
            n_err++;
            $display("FAIL %s_timeout: %0d bytes pending, want 0",
                     nm, exp_q.size());
        end
        idle(2);
        chk_reg({nm, "_status"}, 4'h4, 32'h2);
    endtask

    // Line receiver: every bit must hold for exactly CPB cycles.
    initial begin : monitor
        logic [9:0] fr;
        logic [7:0] e;
        bit ab;
        bit bad;
        forever begin
            @(negedge CLK);
            if (RESET === 1'b1 && TxD === 1'b0) begin
                starts.push_back(cyc);
                ab  = 1'b0;
                bad = 1'b0;
                fr  = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge CLK);
                        if (RESET !== 1'b1) ab = 1'b1;
                        if (c == 0) fr[b] = TxD;
                        else if (TxD !== fr[b]) bad = 1'b1;
                    end
                end
                if (!ab) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL frame_unexpected: got 0x%03h want none",
                                 fr);
                    end else begin
                        e = exp_q.pop_front();
                        if (bad || fr[0] !== 1'b0 || fr[9] !== 1'b1 ||
                            fr[8:1] !== e) begin
                            n_err++;
                            $display("FAIL frame: got 0x%03h glitch=%0d want 0x%03h",
                                     fr, bad, {1'b1, e, 1'b0});
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d;
        logic [7:0]  b;
        logic [3:0]  a;
        int n, busy_cnt, mode, nz;

        bus.IOWriteEn   = 1'b0;
        bus.IOAddr      = 4'h0;
        bus.IOWriteData = '0;
        RESET = 1'b0;
        @(negedge CLK);
        idle(1);
        chk("rst_txd", {31'd0, TxD}, 32'h1);
        chk_reg("rst_status", 4'h4, 32'h2);
        chk_reg("rst_ctrl", 4'h8, 32'h0);
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h77);
        chk_reg("rst_wr_ctrl", 4'h8, 32'h0);
        chk_reg("rst_wr_status", 4'h4, 32'h2);
        RESET = 1'b1;
        idle(1);
        chk_reg("txdata_reads0", 4'h0, 32'h0);

        // Single frame with exact latency and busy window
        wr(4'h8, 32'h1);
        exp_q.push_back(8'hA5);
        wr(4'h0, 32'hA5);
        chk("lat_pre", {31'd0, TxD}, 32'h1);
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            rd(4'h4, d);
            if (d[2]) busy_cnt++;
            if (i == 0) chk("lat_start", {31'd0, TxD}, 32'h0);
        end
        chk("busy_cycles", busy_cnt, 10 * CPB);
        drain("single");

        wr(4'h8, 32'h0);
        for (int i = 0; i < 5; i++) wr(4'h0, 32'h11 + i);
        chk_reg("ovf_status", 4'h4, 32'h49);
        wr(4'h4, 32'h0);
        chk_reg("ovf_clear", 4'h4, 32'h41);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h11 + 8'(i));
        wr(4'h8, 32'h1);
        drain("ovf");

        // Push on full accepted on the edge the FSM pops
        wr(4'h8, 32'h0);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h21 + 8'(i));
        for (int i = 0; i < 4; i++) wr(4'h0, 32'h21 + i);
        starts.delete();
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h25);
        chk_reg("push_pop_status", 4'h4, 32'h45);
        drain("push_pop");
        chk("push_pop_frames", starts.size(), 5);
        for (int i = 1; i < 5 && i < starts.size(); i++)
            chk("frame_gap", starts[i] - starts[i-1], 10 * CPB + 1);

        exp_q.push_back(8'h31);
        wr(4'h0, 32'h31);
        wr(4'h0, 32'h32);
        wr(4'h0, 32'h33);
        idle(10);
        wr(4'h8, 32'h3);
        chk_reg("flush_status", 4'h4, 32'h6);
        drain("flush");
        idle(60);
        chk_reg("flush_after", 4'h4, 32'h2);

        wr(4'h0, 32'h5A);
        wr(4'h0, 32'h5B);
        wr(4'h0, 32'h5C);
        idle(12);
        RESET = 1'b0;
        @(negedge CLK);
        chk("midrst_txd", {31'd0, TxD}, 32'h1);
        @(negedge CLK);
        RESET = 1'b1;
        exp_q.delete();
        chk_reg("midrst_status", 4'h4, 32'h2);
        chk_reg("midrst_ctrl", 4'h8, 32'h0);
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TxD !== 1'b1) nz++;
        end
        chk("midrst_quiet", nz, 0);

        wr(4'h8, 32'h1);
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 1);
            if (mode == 0) begin
                wr(4'h8, 32'h0);
                n = $urandom_range(1, DEPTH);
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    wr(4'h0, {24'd0, b});
                end
                chk_reg("rand_count", 4'h4,
                        32'(n << 4) | ((n == DEPTH) ? 32'h1 : 32'h0));
                wr(4'h8, 32'h1);
            end else begin
                n = $urandom_range(1, DEPTH + 1);
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    wr(4'h0, {24'd0, b});
                    idle($urandom_range(0, 2));
                end
            end
            drain("rand");
            a = 4'($urandom_range(0, 15));
            if (a != 4'h0 && a != 4'h4 && a != 4'h8) begin
                wr(a, $urandom);
                chk_reg("unmapped_rd", a, 32'h0);
                chk_reg("unmapped_ctrl", 4'h8, 32'h1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
